// File: rtl/tdm_demux_ctrl.sv
// TDM demultiplexer controller: locks to a frame marker on a serial stream,
// collects eight one-bit slots into a shadow frame and publishes it as y.
module tdm_demux_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       a,
    input  logic       sync,
    input  logic [7:0] mask,
    output logic [2:0] s,
    output logic [7:0] y,
    output logic       frame_vld,
    output logic       lock,
    output logic       err
);

    // Output handshake: frame_vld is a valid-only strobe with no ready; y is
    // stable from the frame_vld cycle until the next frame_vld and must be
    // taken by the consumer while it holds.
    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t     state, state_nx;
    logic [2:0] s_nx;
    logic [7:0] shadow, shadow_nx;
    logic [7:0] y_nx;
    logic [1:0] miss, miss_nx, miss_inc;
    logic       vld_nx, err_nx;
    logic       a_m;

    // In HUNT s is 0, so this also masks the slot-0 bit taken on lock-in.
    assign a_m      = a & mask[s];
    assign miss_inc = (miss == 2'd3) ? 2'd3 : miss + 2'd1;
    assign lock     = (state == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HUNT;
            s         <= 3'd0;
            shadow    <= 8'h00;
            y         <= 8'h00;
            miss      <= 2'd0;
            frame_vld <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nx;
            s         <= s_nx;
            shadow    <= shadow_nx;
            y         <= y_nx;
            miss      <= miss_nx;
            frame_vld <= vld_nx;
            err       <= err_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        s_nx      = s;
        shadow_nx = shadow;
        y_nx      = y;
        miss_nx   = miss;
        vld_nx    = 1'b0;
        err_nx    = 1'b0;

        if (!en) begin
            state_nx  = HUNT;
            s_nx      = 3'd0;
            shadow_nx = 8'h00;
            miss_nx   = 2'd0;
        end else begin
            case (state)
                HUNT: begin
                    if (sync) begin
                        state_nx  = RUN;
                        shadow_nx = {7'd0, a_m};
                        s_nx      = 3'd1;
                        miss_nx   = 2'd0;
                    end
                end
                RUN: begin
                    if (sync && (s != 3'd0)) begin
                        // Frame slip: drop the partial frame and realign here.
                        err_nx    = 1'b1;
                        shadow_nx = {7'd0, a_m};
                        s_nx      = 3'd1;
                        miss_nx   = 2'd0;
                    end else if (s == 3'd0) begin
                        if (!sync && (miss_inc >= 2'd2)) begin
                            state_nx  = HUNT;
                            s_nx      = 3'd0;
                            shadow_nx = 8'h00;
                            miss_nx   = 2'd0;
                        end else begin
                            miss_nx   = sync ? 2'd0 : miss_inc;
                            shadow_nx = {7'd0, a_m};
                            s_nx      = 3'd1;
                        end
                    end else if (s == 3'd7) begin
                        y_nx      = {a_m, shadow[6:0]};
                        vld_nx    = 1'b1;
                        shadow_nx = 8'h00;
                        s_nx      = 3'd0;
                    end else begin
                        shadow_nx[s] = a_m;
                        s_nx         = s + 3'd1;
                    end
                end
                default: begin
                    state_nx = HUNT;
                end
            endcase
        end
    end

endmodule
